player_move: RTL and testbench
==============================

// Module: player_move
// PURPOSE
//  Horizontal motion controller for a player sprite on the floor line.
//  Speed ramps up while a direction is held. Motion is clamped to the screen.
//  Includes a timed "hit" freeze with blink, and a respawn input.
//  Sits between keypad decode / collision logic and the sprite drawer; state advances once per frame.
// PARAMETERS
//  SCREEN_W      640  visible width in pixels
//  CHAR_W        32   sprite width
//  CHAR_HIGHT    32   sprite height
//  FLOOR_Y       448  y of floor line; topLeftY = FLOOR_Y-CHAR_HIGHT
//  INITIAL_X     320  spawn/respawn x
//  MAX_SPEED     4    max px/frame (1..15)
//  ACCEL_FRAMES  8    held frames per +1 speed step (>=1)
//  HIT_FRAMES    60   freeze length in frames (>=1)
//  BLINK_FRAMES  4    visible toggle period during HIT
// PORTS
//  clk           in   1   system clock
//  resetN        in   1   async active-low reset
//  startOfFrame  in   1   1-cycle pulse per frame; all motion/timers advance only on it
//  leftPress     in   1   left key level
//  rightPress    in   1   right key level
//  leftCrash     in   1   wall/obstacle on left; blocks left motion
//  rightCrash    in   1   wall/obstacle on right; blocks right motion
//  hit           in   1   ball hit level/pulse; sampled on startOfFrame
//  restart       in   1   synchronous respawn, any cycle
//  topLeftX      out  11  sprite x
//  topLeftY      out  11  constant FLOOR_Y-CHAR_HIGHT
//  facingLeft    out  1   last commanded direction
//  moving        out  1   1 when state==WALK
//  frozen        out  1   1 when state==HIT
//  visible       out  1   sprite enable for drawer
// BEHAVIOUR
//  Reset: topLeftX=INITIAL_X, state=IDLE, speed=1, ramp cnt=0, hit cnt=0,
//   facingLeft=0, visible=1. All outputs are registered except topLeftY
//   (constant) and moving/frozen (decoded from state).
//  Priority per clk: resetN > restart > startOfFrame update.
//   restart: same values as reset, applied next edge, regardless of frame.
//  Direction cmd: L = leftPress&!rightPress; R = rightPress&!leftPress.
//   Both pressed or neither = none.
//  FSM (transitions only on startOfFrame):
//   IDLE: hit->HIT. cmd L/R->WALK, moving this same frame at speed 1.
//   WALK: hit->HIT. cmd none->IDLE with speed=1, cnt=0.
//     Same dir held: cnt++. When cnt==ACCEL_FRAMES-1: cnt=0,
//       speed=min(speed+1,MAX_SPEED).
//     Dir reversal: speed=1, cnt=0, facingLeft updates, move 1px new dir.
//   HIT: no motion. Further hit ignored. hitcnt++ each frame.
//     visible toggles every BLINK_FRAMES frames.
//     At hitcnt==HIT_FRAMES-1: ->IDLE, visible=1, hitcnt=0, speed=1.
//  Position math: signed 12-bit nx = x +/- speed.
//   Clamp to [0, SCREEN_W-CHAR_W]; never wraps below 0 or above the max.
//   leftCrash blocks L, rightCrash blocks R: x holds, state stays WALK,
//     and the speed ramp continues.
//  hit has priority over cmd in the same frame: no move, enter HIT.
//  Inputs between startOfFrame pulses are ignored (except restart).
// TESTING
//  1 Reset, idle 5 frames -> topLeftX=320, visible=1, moving=0, frozen=0.
//  2 rightPress 20 frames (ACCEL=8,MAX=4) -> speed 1x8,2x8,3x4; X=320+8+16+12=356.
//  3 X=3, leftPress at speed 4 -> X=0 next frame, stays 0. X=605, R speed 4 -> 608 clamp.
//  4 Both keys pressed -> no motion, IDLE. Reverse L->R mid-ramp -> step +1, facingLeft=0.
//  5 hit while walking -> frozen for 60 frames, X constant, visible toggles every 4 frames.
//    Frame 60 -> IDLE, visible=1. A second hit during HIT -> no extension.
//  6 restart mid-HIT (not on frame) -> next clk X=320, IDLE, visible=1.
//    resetN low mid-WALK -> immediate reset values.

Source files
------------

// File: rtl/player_move.sv
// player_move: frame-paced horizontal motion controller for the player sprite.
// Handles the speed ramp, screen clamp, wall blocking, hit freeze with blink and respawn.
module player_move #(
    parameter int SCREEN_W     = 640,
    parameter int CHAR_W       = 32,
    parameter int CHAR_HIGHT   = 32,
    parameter int FLOOR_Y      = 448,
    parameter int INITIAL_X    = 320,
    parameter int MAX_SPEED    = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int HIT_FRAMES   = 60,
    parameter int BLINK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftPress,
    input  logic        rightPress,
    input  logic        leftCrash,
    input  logic        rightCrash,
    input  logic        hit,
    input  logic        restart,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        facingLeft,
    output logic        moving,
    output logic        frozen,
    output logic        visible
);

    localparam int CNT_W   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int HIT_W   = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]        X_INIT     = 11'(INITIAL_X);
    localparam logic signed [11:0] X_MAX      = 12'(SCREEN_W - CHAR_W);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ACCEL_FRAMES - 1);
    localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HIT_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [4:0]         SPEED_MAX  = 5'(MAX_SPEED);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         speed;
    logic [CNT_W-1:0]   rampCnt;
    logic [HIT_W-1:0]   hitCnt;
    logic [BLINK_W-1:0] blinkCnt;

    logic               cmdLeft;
    logic               cmdRight;
    logic               cmdAny;
    logic               sameDir;
    logic [3:0]         stepSpeed;
    logic [CNT_W-1:0]   baseCnt;
    logic [CNT_W-1:0]   nextCnt;
    logic [3:0]         nextSpeed;
    logic [4:0]         bumped;
    logic signed [11:0] curX;
    logic signed [11:0] delta;
    logic signed [11:0] nx;
    logic [10:0]        stepX;

    assign topLeftY = 11'(FLOOR_Y - CHAR_HIGHT);
    assign moving   = (state == WALK);
    assign frozen   = (state == HIT);
    assign cmdLeft  = leftPress & ~rightPress;
    assign cmdRight = rightPress & ~leftPress;
    assign cmdAny   = cmdLeft | cmdRight;
    assign sameDir  = (state == WALK) && ((cmdLeft && facingLeft) || (cmdRight && !facingLeft));

    // Step speed, ramp advance and clamped candidate position for this frame
    always_comb begin
        stepSpeed = 4'd1;
        baseCnt   = '0;
        nextCnt   = '0;
        nextSpeed = 4'd1;
        nx        = 12'sd0;
        stepX     = topLeftX;
        // A fresh start or a reversal always steps at speed 1 from an empty ramp
        if (sameDir) begin
            stepSpeed = speed;
            baseCnt   = rampCnt;
        end else begin
            stepSpeed = 4'd1;
            baseCnt   = '0;
        end
        bumped = {1'b0, stepSpeed} + 5'd1;
        if (baseCnt == CNT_LAST) begin
            nextCnt   = '0;
            nextSpeed = (bumped > SPEED_MAX) ? SPEED_MAX[3:0] : bumped[3:0];
        end else begin
            nextCnt   = baseCnt + CNT_W'(1);
            nextSpeed = stepSpeed;
        end
        curX  = $signed({1'b0, topLeftX});
        delta = $signed({8'd0, stepSpeed});
        if (cmdLeft && !leftCrash) begin
            nx = curX - delta;
        end else if (cmdRight && !rightCrash) begin
            nx = curX + delta;
        end else begin
            nx = curX;
        end
        if (nx < 12'sd0) begin
            stepX = 11'd0;
        end else if (nx > X_MAX) begin
            stepX = X_MAX[10:0];
        end else begin
            stepX = nx[10:0];
        end
    end

    // Motion FSM: respawn any cycle, everything else only on the frame pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            topLeftX   <= X_INIT;
            speed      <= 4'd1;
            rampCnt    <= '0;
            hitCnt     <= '0;
            blinkCnt   <= '0;
            facingLeft <= 1'b0;
            visible    <= 1'b1;
        end else if (restart) begin
            state      <= IDLE;
            topLeftX   <= X_INIT;
            speed      <= 4'd1;
            rampCnt    <= '0;
            hitCnt     <= '0;
            blinkCnt   <= '0;
            facingLeft <= 1'b0;
            visible    <= 1'b1;
        end else if (startOfFrame) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state    <= HIT;
                        hitCnt   <= '0;
                        blinkCnt <= '0;
                    end else if (cmdAny) begin
                        state      <= WALK;
                        topLeftX   <= stepX;
                        speed      <= nextSpeed;
                        rampCnt    <= nextCnt;
                        facingLeft <= cmdLeft;
                    end else begin
                        speed   <= 4'd1;
                        rampCnt <= '0;
                    end
                end
                WALK: begin
                    if (hit) begin
                        state    <= HIT;
                        hitCnt   <= '0;
                        blinkCnt <= '0;
                        speed    <= 4'd1;
                        rampCnt  <= '0;
                    end else if (!cmdAny) begin
                        state   <= IDLE;
                        speed   <= 4'd1;
                        rampCnt <= '0;
                    end else if (sameDir) begin
                        topLeftX <= stepX;
                        speed    <= nextSpeed;
                        rampCnt  <= nextCnt;
                    end else begin
                        topLeftX   <= stepX;
                        speed      <= 4'd1;
                        rampCnt    <= '0;
                        facingLeft <= cmdLeft;
                    end
                end
                HIT: begin
                    if (hitCnt == HIT_LAST) begin
                        state    <= IDLE;
                        visible  <= 1'b1;
                        hitCnt   <= '0;
                        blinkCnt <= '0;
                        speed    <= 4'd1;
                        rampCnt  <= '0;
                    end else begin
                        hitCnt <= hitCnt + HIT_W'(1);
                        if (blinkCnt == BLINK_LAST) begin
                            blinkCnt <= '0;
                            visible  <= ~visible;
                        end else begin
                            blinkCnt <= blinkCnt + BLINK_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_move.sv
// Scoreboard bench for player_move: a frame-level reference model queues the expected
// outputs after every update and an independent monitor checks them against the DUT.
module tb_player_move;

    localparam int SCREEN_W = 640, CHAR_W = 32, CHAR_HIGHT = 32, FLOOR_Y = 448;
    localparam int INITIAL_X = 320, MAX_SPEED = 4, ACCEL_FRAMES = 8;
    localparam int HIT_FRAMES = 60, BLINK_FRAMES = 4;
    localparam int X_MAX = SCREEN_W - CHAR_W;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        leftPress = 1'b0, rightPress = 1'b0;
    logic        leftCrash = 1'b0, rightCrash = 1'b0;
    logic        hit = 1'b0, restart = 1'b0;
    logic [10:0] topLeftX, topLeftY;
    logic        facingLeft, moving, frozen, visible;

    player_move dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .leftPress(leftPress), .rightPress(rightPress),
        .leftCrash(leftCrash), .rightCrash(rightCrash),
        .hit(hit), .restart(restart),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .facingLeft(facingLeft),
        .moving(moving), .frozen(frozen), .visible(visible)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        bit faceL;
        bit mov;
        bit frz;
        bit vis;
    } exp_t;

    exp_t expQ[$];
    int   nCmp = 0;
    int   nBad = 0;

    // Reference model state, in terms of the game rules
    int mX, mSpeed, mHeld, mHitFrames;
    bit mWalk, mFrozen, mFaceL, mVis;

    task automatic cmp(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mX = INITIAL_X; mSpeed = 1; mHeld = 0; mHitFrames = 0;
        mWalk = 0; mFrozen = 0; mFaceL = 0; mVis = 1;
    endtask

    task automatic pushExp();
        exp_t e;
        e.x = mX; e.faceL = mFaceL; e.mov = mWalk; e.frz = mFrozen; e.vis = mVis;
        expQ.push_back(e);
    endtask

    task automatic step(input int dir, input int spd, input bit blocked);
        int n;
        if (!blocked) begin
            n = mX + dir * spd;
            if (n < 0) n = 0;
            if (n > X_MAX) n = X_MAX;
            mX = n;
        end
    endtask

    task automatic modelFrame(input bit l, input bit r, input bit lc, input bit rc, input bit h);
        int dir;
        bit blocked;
        dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        blocked = (dir < 0) ? lc : rc;
        if (mFrozen) begin
            mHitFrames++;
            if (mHitFrames == HIT_FRAMES) begin
                mFrozen = 0; mVis = 1; mSpeed = 1; mHeld = 0;
            end else if (mHitFrames % BLINK_FRAMES == 0) begin
                mVis = !mVis;
            end
        end else if (h) begin
            mFrozen = 1; mWalk = 0; mHitFrames = 0;
        end else if (dir == 0) begin
            mWalk = 0; mSpeed = 1; mHeld = 0;
        end else begin
            if (mWalk && ((dir < 0) == mFaceL)) begin
                step(dir, mSpeed, blocked);
                mHeld++;
            end else if (mWalk) begin
                mFaceL = (dir < 0); mSpeed = 1; mHeld = 0;
                step(dir, 1, blocked);
            end else begin
                mWalk = 1; mFaceL = (dir < 0); mSpeed = 1; mHeld = 1;
                step(dir, 1, blocked);
            end
            if (mHeld == ACCEL_FRAMES) begin
                mHeld = 0;
                if (mSpeed < MAX_SPEED) mSpeed++;
            end
        end
    endtask

    // Inputs wiggle between frame pulses; the DUT must ignore them
    task automatic noiseGap();
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            @(negedge clk);
            leftPress = 1'($urandom); rightPress = 1'($urandom);
            leftCrash = 1'($urandom); rightCrash = 1'($urandom);
            hit = 1'($urandom);
        end
    endtask

    task automatic frame(input bit l, input bit r, input bit lc, input bit rc, input bit h);
        @(negedge clk);
        leftPress = l; rightPress = r; leftCrash = lc; rightCrash = rc; hit = h;
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        modelFrame(l, r, lc, rc, h);
        pushExp();
        noiseGap();
    endtask

    task automatic doRestart();
        @(negedge clk);
        #2;
        restart = 1'b1;
        startOfFrame = 1'($urandom);
        leftPress = 1'($urandom); rightPress = 1'($urandom); hit = 1'($urandom);
        @(posedge clk);
        #1;
        restart = 1'b0;
        startOfFrame = 1'b0;
        modelReset();
        pushExp();
    endtask

    task automatic doAsyncReset();
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        cmp("async_rst_x", topLeftX, INITIAL_X);
        cmp("async_rst_moving", moving, 0);
        cmp("async_rst_visible", visible, 1);
        modelReset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Monitor: every queued expectation is checked one half-cycle after its update edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                cmp("x", topLeftX, e.x);
                cmp("y", topLeftY, FLOOR_Y - CHAR_HIGHT);
                cmp("facingLeft", facingLeft, e.faceL);
                cmp("moving", moving, e.mov);
                cmp("frozen", frozen, e.frz);
                cmp("visible", visible, e.vis);
            end
        end
    end

    initial begin
        int  dirSel;
        bit  l, r, lc, rc, h;
        int  budget;
        modelReset();
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        pushExp();

        repeat (5) frame(0, 0, 0, 0, 0);
        cmp("idle_x", topLeftX, 320);

        repeat (20) frame(0, 1, 0, 0, 0);
        cmp("ramp_x", topLeftX, 356);

        repeat (80) frame(0, 1, 0, 0, 0);
        cmp("right_clamp_x", topLeftX, X_MAX);
        repeat (200) frame(1, 0, 0, 0, 0);
        cmp("left_clamp_x", topLeftX, 0);

        repeat (3) frame(1, 1, 0, 0, 0);
        cmp("both_moving", moving, 0);

        repeat (10) frame(1, 0, 0, 0, 0);
        repeat (4) frame(1, 0, 1, 0, 0);
        frame(0, 1, 0, 0, 0);
        cmp("reverse_facing", facingLeft, 0);

        repeat (3) frame(0, 1, 0, 0, 0);
        frame(0, 1, 0, 0, 1);
        repeat (HIT_FRAMES - 1) frame(1'($urandom), 1'($urandom), 0, 0, 1'($urandom));
        cmp("hit_still_frozen", frozen, 1);
        frame(0, 0, 0, 0, 1);
        cmp("hit_released", frozen, 0);
        cmp("hit_visible", visible, 1);

        frame(0, 1, 0, 0, 1);
        repeat (10) frame(0, 1, 0, 0, 0);
        doRestart();

        repeat (6) frame(0, 1, 0, 0, 0);
        doAsyncReset();

        dirSel = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) dirSel = $urandom_range(0, 3);
            l  = (dirSel == 1) || (dirSel == 3);
            r  = (dirSel == 2) || (dirSel == 3);
            lc = ($urandom_range(0, 9) == 0);
            rc = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 49) == 0);
            frame(l, r, lc, rc, h);
            if ($urandom_range(0, 149) == 0) doRestart();
        end

        budget = 20;
        while (expQ.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            nCmp++;
            nBad++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
